mem_io_ctrl: RTL and testbench

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

---
 rtl/mem_io_ctrl_pkg.sv | 43 ++++
 rtl/mem_io_ctrl_sync_fifo.sv | 57 +++++
 rtl/mem_io_ctrl.sv | 116 +++++++++++
 tb/tb_mem_io_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_ctrl_pkg.sv
// mem_io_ctrl_pkg: shared address map, region decode and status-byte layout
// for the CPU memory/IO controller.
//   IO_BASE  : RX read / TX push register
//   IO_HALT  : halt write / status read register
//   decode() : classifies a CPU request into RAM or one of the IO actions
package mem_io_ctrl_pkg;

    localparam int          IO_AW     = 18;
    localparam logic [17:0] IO_BASE   = 18'h30000;
    localparam logic [17:0] IO_HALT   = 18'h30004;
    localparam int          REGION_HI = 17;
    localparam int          REGION_LO = 16;
    localparam logic [1:0]  REGION_IO = 2'b11;

    // status byte read from IO_HALT
    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 1;

    // which source feeds cpu_din for an accepted read
    typedef enum logic {
        TAG_RAM = 1'b0,
        TAG_IO  = 1'b1
    } rd_tag_e;

    typedef struct packed {
        logic io;       // request targets the IO region
        logic rx_rd;    // read of IO_BASE
        logic tx_wr;    // write of IO_BASE
        logic halt_wr;  // write of IO_HALT
        logic stat_rd;  // read of IO_HALT
    } io_dec_t;

    function automatic io_dec_t decode(input logic [IO_AW-1:0] a, input logic wr);
        io_dec_t d;
        d.io      = (a[REGION_HI:REGION_LO] == REGION_IO);
        d.rx_rd   = (a == IO_BASE) && !wr;
        d.tx_wr   = (a == IO_BASE) &&  wr;
        d.halt_wr = (a == IO_HALT) &&  wr;
        d.stat_rd = (a == IO_HALT) && !wr;
        return d;
    endfunction

endpackage

// File: rtl/mem_io_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two DEPTH.
//   clk, rst_n : clock, synchronous active-low reset (clears pointers/count)
//   push, din  : write side; a push while full is dropped, even if a pop
//                happens in the same cycle
//   pop, dout  : read side; dout is the head entry, valid when !empty
//   empty, full: occupancy flags derived from a (clog2(DEPTH)+1)-bit count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // storage carries no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // pointers wrap naturally since DEPTH is a power of two
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: routes a simple CPU bus to a synchronous RAM or a small IO map
// (RX byte source, TX FIFO sink, halt flag, status byte).
//   clk_in, rst_n_in          : clock, synchronous active-low reset
//   cpu_a/cpu_dout/cpu_wr     : CPU request (one request per cycle, accepted
//                               on an edge where cpu_rdy=1)
//   cpu_din, cpu_rdy          : registered read data, advance enable
//   ram_a/ram_dout/ram_we/ram_din : single-port RAM, 1-cycle read latency
//   rx_data/rx_valid/rx_pop   : input byte source
//   tx_data/tx_valid/tx_ready : output byte sink fed by the TX FIFO
//   halt                      : sticky stop flag
module mem_io_ctrl
    import mem_io_ctrl_pkg::*;
#(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [31:0]       cpu_a,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_din,
    output logic              cpu_rdy,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_we,
    input  logic [7:0]        ram_din,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              halt
);

    localparam int STAGES = 1;

    io_dec_t       dec;
    logic          tx_full, tx_empty;
    logic          tx_push;
    logic          halt_q;
    logic [7:0]    stat_byte, io_byte_nxt, io_byte;
    rd_tag_e       tag;
    logic [STAGES:0] vld_pipe;
    logic          unused_a;

    assign unused_a = ^cpu_a[31:IO_AW];
    assign dec      = decode(cpu_a[IO_AW-1:0], cpu_wr);

    // Stall sources; reset also holds the CPU so a pending request is dropped.
    always_comb begin
        cpu_rdy = rst_n_in && !halt_q;
        if (dec.tx_wr && tx_full)   cpu_rdy = 1'b0;
        if (dec.rx_rd && !rx_valid) cpu_rdy = 1'b0;
    end

    assign ram_a    = cpu_a[RAM_AW-1:0];
    assign ram_dout = cpu_dout;
    assign ram_we   = cpu_wr && !dec.io && cpu_rdy;
    assign rx_pop   = dec.rx_rd && cpu_rdy;
    assign tx_push  = dec.tx_wr && cpu_rdy;
    assign tx_valid = !tx_empty;
    assign halt     = halt_q;

    always_comb begin
        stat_byte                = '0;
        stat_byte[STAT_TX_FULL]  = tx_full;
        stat_byte[STAT_RX_VALID] = rx_valid;
    end

    // unmapped IO offsets read as zero
    always_comb begin
        io_byte_nxt = '0;
        if (dec.rx_rd)        io_byte_nxt = rx_data;
        else if (dec.stat_rd) io_byte_nxt = stat_byte;
    end

    // vld_pipe[0] marks an accepted read; one stage later the RAM output is
    // valid, so cpu_din is loaded from the source chosen at the accept edge
    // and then holds until the next accepted read completes.
    assign vld_pipe[0] = cpu_rdy && !cpu_wr;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            halt_q           <= 1'b0;
            tag              <= TAG_RAM;
            io_byte          <= '0;
            vld_pipe[STAGES] <= 1'b0;
            cpu_din          <= '0;
        end else begin
            if (cpu_rdy && dec.halt_wr) halt_q <= 1'b1;
            vld_pipe[STAGES] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                tag     <= dec.io ? TAG_IO : TAG_RAM;
                io_byte <= io_byte_nxt;
            end
            if (vld_pipe[STAGES]) cpu_din <= (tag == TAG_IO) ? io_byte : ram_din;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (tx_push),
        .din   (cpu_dout),
        .pop   (tx_valid && tx_ready),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full)
    );

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: directed bench for mem_io_ctrl with a behavioural RAM and a
// TX sink that records every byte handed over.
module tb_mem_io_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;
    int pop_cnt = 0;
    logic [7:0] ram [0:(1<<17)-1];
    logic [7:0] sink [$];

    mem_io_ctrl #(.RAM_AW(17), .TX_DEPTH(16)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
        .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_we(ram_we), .ram_din(ram_din),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .halt(halt)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (ram_we) ram[ram_a] <= ram_dout;
        ram_din <= ram[ram_a];
        if (ram_we) we_cnt <= we_cnt + 1;
        if (rx_pop) pop_cnt <= pop_cnt + 1;
        if (tx_valid && tx_ready) sink.push_back(tx_data);
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic wr, input logic [7:0] d);
        cpu_a = a; cpu_wr = wr; cpu_dout = d;
        #1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; rx_valid = 1'b1; rx_data = 8'h99; tx_ready = 1'b0;
        req(32'h0000_0010, 1'b1, 8'hEE);
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        req(32'h0003_0000, 1'b0, 8'h00);
        n_cmp++; if (rx_pop !== 1'b0) begin n_err++; $display("FAIL rst_rx_pop: got %b want 0", rx_pop); end
        n_cmp++; if (cpu_rdy !== 1'b0) begin n_err++; $display("FAIL rst_cpu_rdy: got %b want 0", cpu_rdy); end
        step(); step();
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL rst_halt: got %b want 0", halt); end
        n_cmp++; if (cpu_din !== 8'h00) begin n_err++; $display("FAIL rst_cpu_din: got %h want 00", cpu_din); end
        n_cmp++; if (pop_cnt != 0) begin n_err++; $display("FAIL rst_no_pop: got %0d want 0", pop_cnt); end
        rx_valid = 1'b0;
        idle();
        rst_n_in = 1'b1; #1;
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL rst_release_rdy: got %b want 1", cpu_rdy); end
    endtask

    task automatic test_ram_rw();
        int we0;
        we0 = we_cnt;
        req(32'h0000_0010, 1'b1, 8'hA5);
        n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL ram_we_wr: got %b want 1", ram_we); end
        step();
        // alias address: bits above the decode are ignored
        req(32'hFFFC_0010, 1'b0, 8'h00);
        n_cmp++; if (ram_a !== 17'h00010) begin n_err++; $display("FAIL ram_a_alias: got %h want 00010", ram_a); end
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL ram_we_rd: got %b want 0", ram_we); end
        step();
        req(32'h0000_0040, 1'b0, 8'h00);
        step();
        n_cmp++; if (cpu_din !== 8'hA5) begin n_err++; $display("FAIL ram_readback: got %h want a5", cpu_din); end
        n_cmp++; if (we_cnt - we0 != 1) begin n_err++; $display("FAIL ram_we_pulses: got %0d want 1", we_cnt - we0); end
        idle();
    endtask

    task automatic test_back_to_back();
        req(32'h0000_0020, 1'b1, 8'h11); step();
        req(32'h0000_0021, 1'b1, 8'h22); step();
        req(32'h0000_0020, 1'b0, 8'h00); step();
        req(32'h0000_0021, 1'b0, 8'h00); step();
        n_cmp++; if (cpu_din !== 8'h11) begin n_err++; $display("FAIL b2b_first: got %h want 11", cpu_din); end
        idle(); step();
        n_cmp++; if (cpu_din !== 8'h22) begin n_err++; $display("FAIL b2b_second: got %h want 22", cpu_din); end
    endtask

    task automatic test_tx_full();
        int s0, bad, k;
        s0 = sink.size(); bad = 0;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req(32'h0003_0000, 1'b1, 8'(8'h30 + i));
            if (cpu_rdy !== 1'b1) bad++;
            step();
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL tx_fill_rdy: got %0d stalls want 0", bad); end
        req(32'h0003_0000, 1'b1, 8'h40);
        for (int i = 0; i < 3; i++) begin
            if (cpu_rdy !== 1'b0) bad++;
            step();
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL tx_full_stall: got %0d ready cycles want 0", bad); end
        n_cmp++; if (tx_data !== 8'h30 || tx_valid !== 1'b1) begin n_err++; $display("FAIL tx_head: got %h/%b want 30/1", tx_data, tx_valid); end
        tx_ready = 1'b1; #1;
        n_cmp++; if (cpu_rdy !== 1'b0) begin n_err++; $display("FAIL tx_full_pop_same_cycle: got %b want 0", cpu_rdy); end
        step();
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL tx_rdy_after_pop: got %b want 1", cpu_rdy); end
        step();
        idle();
        k = 0;
        while (tx_valid === 1'b1 && k < 40) begin step(); k++; end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_drain_timeout: tx_valid %b want 0", tx_valid); end
        n_cmp++; if (sink.size() - s0 != 17) begin n_err++; $display("FAIL tx_count: got %0d want 17", sink.size() - s0); end
        bad = 0;
        for (int i = 0; i < 17 && s0 + i < sink.size(); i++)
            if (sink[s0+i] !== ((i < 16) ? 8'(8'h30 + i) : 8'h40)) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL tx_order: got %0d wrong bytes want 0", bad); end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx_stall();
        int p0, bad;
        p0 = pop_cnt; bad = 0;
        rx_valid = 1'b0; rx_data = 8'h00;
        req(32'h0003_0000, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            if (cpu_rdy !== 1'b0 || rx_pop !== 1'b0) bad++;
            step();
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rx_stall: got %0d bad cycles want 0", bad); end
        rx_data = 8'h41; rx_valid = 1'b1; #1;
        n_cmp++; if (rx_pop !== 1'b1 || cpu_rdy !== 1'b1) begin n_err++; $display("FAIL rx_accept: got pop %b rdy %b want 1 1", rx_pop, cpu_rdy); end
        step();
        rx_valid = 1'b0;
        idle(); step();
        n_cmp++; if (cpu_din !== 8'h41) begin n_err++; $display("FAIL rx_data: got %h want 41", cpu_din); end
        n_cmp++; if (pop_cnt - p0 != 1) begin n_err++; $display("FAIL rx_pop_count: got %0d want 1", pop_cnt - p0); end
    endtask

    task automatic test_status();
        int p0, s0, k;
        p0 = pop_cnt; s0 = sink.size();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin req(32'h0003_0000, 1'b1, 8'(8'h60 + i)); step(); end
        rx_valid = 1'b1; rx_data = 8'h77;
        req(32'h0003_0004, 1'b0, 8'h00); step();
        req(32'h0003_0008, 1'b0, 8'h00); step();
        n_cmp++; if (cpu_din !== 8'h03) begin n_err++; $display("FAIL status_full_rx: got %h want 03", cpu_din); end
        idle(); step();
        n_cmp++; if (cpu_din !== 8'h00) begin n_err++; $display("FAIL io_unmapped: got %h want 00", cpu_din); end
        n_cmp++; if (pop_cnt != p0) begin n_err++; $display("FAIL status_no_pop: got %0d want %0d", pop_cnt, p0); end
        rx_valid = 1'b0; tx_ready = 1'b1;
        k = 0;
        while (tx_valid === 1'b1 && k < 40) begin step(); k++; end
        n_cmp++; if (sink.size() - s0 != 16) begin n_err++; $display("FAIL status_drain: got %0d want 16", sink.size() - s0); end
        tx_ready = 1'b0;
    endtask

    task automatic test_halt_drain();
        int s0, bad;
        s0 = sink.size(); bad = 0;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin req(32'h0003_0000, 1'b1, 8'(8'h51 + i)); step(); end
        req(32'h0003_0004, 1'b1, 8'h00);
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL halt_wr_rdy: got %b want 1", cpu_rdy); end
        step();
        n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_set: got %b want 1", halt); end
        req(32'h0000_0010, 1'b1, 8'h5A);
        n_cmp++; if (cpu_rdy !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL halt_blocks: got rdy %b we %b want 0 0", cpu_rdy, ram_we); end
        tx_ready = 1'b1;
        step(); step(); step(); step();
        n_cmp++; if (sink.size() - s0 != 3) begin n_err++; $display("FAIL halt_drain_count: got %0d want 3", sink.size() - s0); end
        for (int i = 0; i < 3 && s0 + i < sink.size(); i++)
            if (sink[s0+i] !== 8'(8'h51 + i)) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL halt_drain_order: got %0d wrong want 0", bad); end
        n_cmp++; if (halt !== 1'b1 || cpu_rdy !== 1'b0) begin n_err++; $display("FAIL halt_sticky: got halt %b rdy %b want 1 0", halt, cpu_rdy); end
        idle();
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_stall();
        int s0;
        rst_n_in = 1'b0; step(); rst_n_in = 1'b1;
        req(32'h0000_0010, 1'b0, 8'h00); step();
        idle(); step();
        n_cmp++; if (cpu_din !== 8'hA5) begin n_err++; $display("FAIL rs_pre_read: got %h want a5", cpu_din); end
        for (int i = 0; i < 16; i++) begin req(32'h0003_0000, 1'b1, 8'(8'h70 + i)); step(); end
        req(32'h0003_0000, 1'b1, 8'h80); step();
        n_cmp++; if (cpu_rdy !== 1'b0) begin n_err++; $display("FAIL rs_stalled: got %b want 0", cpu_rdy); end
        s0 = sink.size();
        rst_n_in = 1'b0; step();
        n_cmp++; if (tx_valid !== 1'b0 || halt !== 1'b0 || cpu_din !== 8'h00) begin
            n_err++; $display("FAIL rs_cleared: got tx_valid %b halt %b din %h want 0 0 00", tx_valid, halt, cpu_din); end
        rst_n_in = 1'b1;
        idle(); step(); step();
        n_cmp++; if (tx_valid !== 1'b0 || sink.size() != s0) begin
            n_err++; $display("FAIL rs_no_push: got tx_valid %b sink +%0d want 0 +0", tx_valid, sink.size() - s0); end
    endtask

    initial begin
        rst_n_in = 1'b0; cpu_a = '0; cpu_dout = '0; cpu_wr = 1'b0;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        test_reset();
        test_ram_rw();
        test_back_to_back();
        test_tx_full();
        test_rx_stall();
        test_status();
        test_halt_drain();
        test_reset_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
